// File: rtl/inertial_sensor_reader.sv
// -----------------------------------------------------------------------------
// InertialSensorReader
//
// Purpose:
//   Producer side of the inertial sample interface. After reset it waits a
//   power-up interval, writes four configuration registers of the 6-axis
//   sensor through the SPI master, then services the sensor's data-ready
//   interrupt by reading four byte registers per sample. Each finished sample
//   is presented as ptch_rt/AZ together with a one-cycle vld strobe.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   INT          data-ready interrupt from the sensor (asynchronous to clk)
//   spi_done     one-cycle pulse from the SPI master: transaction complete
//   spi_rd_data  SPI receive word, valid while spi_done is high
//   spi_wrt      one-cycle pulse: start an SPI transaction
//   spi_cmd      SPI command word, held from spi_wrt until spi_done
//   vld          one-cycle pulse: new ptch_rt/AZ sample
//   ptch_rt      raw pitch rate, {high byte, low byte}
//   AZ           raw Z acceleration, {high byte, low byte}
// -----------------------------------------------------------------------------
module inertial_sensor_reader #(
    parameter int INIT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        spi_done,
    input  logic [15:0] spi_rd_data,
    output logic        spi_wrt,
    output logic [15:0] spi_cmd,
    output logic        vld,
    output logic [15:0] ptch_rt,
    output logic [15:0] AZ
);

    localparam int CNT_W = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

    typedef enum logic [3:0] {
        WAIT_PWR,
        CFG0,
        CFG1,
        CFG2,
        CFG3,
        IDLE,
        RD_PL,
        RD_PH,
        RD_AL,
        RD_AH,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              intMeta_q, intSync_q;
    logic [7:0]        pl_q, pl_d, ph_q, ph_d, al_q, al_d, ah_q, ah_d;
    logic              spiWrt_q, spiWrt_d;
    logic [15:0]       spiCmd_q, spiCmd_d;
    logic              vld_q, vld_d;
    logic [15:0]       ptch_q, ptch_d, az_q, az_d;

    // The sensor returns one byte per read; the upper half of the receive
    // word carries nothing useful and is deliberately dropped.
    logic unusedRdHigh;
    assign unusedRdHigh = ^spi_rd_data[15:8];

    // Command word sent on entry to each transaction state.
    function automatic logic [15:0] cmdFor(input state_t s);
        case (s)
            CFG0:    return 16'h0D02;
            CFG1:    return 16'h1053;
            CFG2:    return 16'h1150;
            CFG3:    return 16'h1460;
            RD_PL:   return 16'hA200;
            RD_PH:   return 16'hA300;
            RD_AL:   return 16'hAC00;
            RD_AH:   return 16'hAD00;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic isTxn(input state_t s);
        case (s)
            CFG0, CFG1, CFG2, CFG3, RD_PL, RD_PH, RD_AL, RD_AH: return 1'b1;
            default:                                           return 1'b0;
        endcase
    endfunction

    // Two-flop synchronizer for the asynchronous data-ready interrupt; only
    // the second flop is ever looked at by the sequencer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            intMeta_q <= 1'b0;
            intSync_q <= 1'b0;
        end else begin
            intMeta_q <= INT;
            intSync_q <= intMeta_q;
        end
    end

    // Sequencer next state. Each transaction state sits waiting for
    // spi_done; spi_done seen anywhere else simply falls through the case.
    // A start pulse and its command are produced whenever the next state is
    // a transaction state different from the current one, so the pulse lands
    // in the first cycle of that state and never in the cycle of a done.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pl_d     = pl_q;
        ph_d     = ph_q;
        al_d     = al_q;
        ah_d     = ah_q;
        spiWrt_d = 1'b0;
        spiCmd_d = spiCmd_q;
        vld_d    = 1'b0;
        ptch_d   = ptch_q;
        az_d     = az_q;

        case (state_q)
            WAIT_PWR: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = CFG0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CFG0:  if (spi_done) state_d = CFG1;
            CFG1:  if (spi_done) state_d = CFG2;
            CFG2:  if (spi_done) state_d = CFG3;
            CFG3:  if (spi_done) state_d = IDLE;
            IDLE:  if (intSync_q) state_d = RD_PL;
            RD_PL: begin
                if (spi_done) begin
                    pl_d    = spi_rd_data[7:0];
                    state_d = RD_PH;
                end
            end
            RD_PH: begin
                if (spi_done) begin
                    ph_d    = spi_rd_data[7:0];
                    state_d = RD_AL;
                end
            end
            RD_AL: begin
                if (spi_done) begin
                    al_d    = spi_rd_data[7:0];
                    state_d = RD_AH;
                end
            end
            RD_AH: begin
                if (spi_done) begin
                    ah_d    = spi_rd_data[7:0];
                    state_d = DONE;
                end
            end
            DONE: begin
                ptch_d  = {ph_q, pl_q};
                az_d    = {ah_q, al_q};
                vld_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = WAIT_PWR;
        endcase

        if ((state_d != state_q) && isTxn(state_d)) begin
            spiWrt_d = 1'b1;
            spiCmd_d = cmdFor(state_d);
        end
    end

    // All sequencer state and every output are registered; reset returns
    // everything to zero and the power-up wait starts over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= WAIT_PWR;
            cnt_q    <= '0;
            pl_q     <= '0;
            ph_q     <= '0;
            al_q     <= '0;
            ah_q     <= '0;
            spiWrt_q <= 1'b0;
            spiCmd_q <= '0;
            vld_q    <= 1'b0;
            ptch_q   <= '0;
            az_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pl_q     <= pl_d;
            ph_q     <= ph_d;
            al_q     <= al_d;
            ah_q     <= ah_d;
            spiWrt_q <= spiWrt_d;
            spiCmd_q <= spiCmd_d;
            vld_q    <= vld_d;
            ptch_q   <= ptch_d;
            az_q     <= az_d;
        end
    end

    assign spi_wrt = spiWrt_q;
    assign spi_cmd = spiCmd_q;
    assign vld     = vld_q;
    assign ptch_rt = ptch_q;
    assign AZ      = az_q;

endmodule

// File: tb/tb_inertial_sensor_reader.sv
// -----------------------------------------------------------------------------
// TbInertialSensorReader
//
// Purpose:
//   Self-checking bench for inertial_sensor_reader. A transaction-level model
//   plays the SPI master (done a fixed number of cycles after each start),
//   tracks which command must come next, when start pulses and sample strobes
//   are due, and which sample words must be on the outputs; it compares the
//   DUT against that every cycle. Directed stimulus adds literal expectations.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_inertial_sensor_reader;

    localparam int INIT    = 16;
    localparam int SPI_LAT = 10;
    localparam int HIST    = 32768;

    logic        clk = 1'b0;
    logic        rst;
    logic        INT;
    logic        spi_done;
    logic [15:0] spi_rd_data;
    logic        spi_wrt;
    logic [15:0] spi_cmd;
    logic        vld;
    logic [15:0] ptch_rt;
    logic [15:0] AZ;

    int checkCount = 0;
    int passCount  = 0;

    // Sample bytes the SPI model hands back, set by the stimulus.
    logic [7:0] smpPL, smpPH, smpAL, smpAH, upperByte;
    bit         injectSpurious;

    // Model state.
    int          tick = 0;
    bit          intHist [HIST];
    bit          outstanding;
    logic [15:0] outCmd;
    int          doneAtTick;
    int          txnIdx;
    int          expWrtTick;
    int          vldTick;
    int          lastAhDoneTick;
    int          vldSeen;
    bit          expV;
    logic [7:0]  capPL, capPH, capAL, capAH;
    logic [15:0] expPtch, expAz, pendPtch, pendAz;
    logic [15:0] cmdLog [$];
    int          sinceRst;

    inertial_sensor_reader #(.INIT_CYCLES(INIT)) dut (
        .clk         (clk),
        .rst         (rst),
        .INT         (INT),
        .spi_done    (spi_done),
        .spi_rd_data (spi_rd_data),
        .spi_wrt     (spi_wrt),
        .spi_cmd     (spi_cmd),
        .vld         (vld),
        .ptch_rt     (ptch_rt),
        .AZ          (AZ)
    );

    always #5 clk = ~clk;

    // Clock edges seen since reset was released.
    always @(posedge clk or posedge rst) begin
        if (rst) sinceRst <= 0;
        else     sinceRst <= sinceRst + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
    endtask

    function automatic logic [15:0] expCmd(input int idx);
        if (idx < 4) begin
            case (idx)
                0:       return 16'h0D02;
                1:       return 16'h1053;
                2:       return 16'h1150;
                default: return 16'h1460;
            endcase
        end
        case ((idx - 4) % 4)
            0:       return 16'hA200;
            1:       return 16'hA300;
            2:       return 16'hAC00;
            default: return 16'hAD00;
        endcase
    endfunction

    function automatic logic [7:0] byteFor(input logic [15:0] cmd);
        case (cmd)
            16'hA200: return smpPL;
            16'hA300: return smpPH;
            16'hAC00: return smpAL;
            16'hAD00: return smpAH;
            default:  return 8'h00;
        endcase
    endfunction

    // Model and SPI responder: one step per negative edge. Inputs from the
    // stimulus only change just after a positive edge, so the INT value seen
    // here is the one the DUT's first synchronizer flop takes at the next
    // positive edge.
    initial begin
        spi_done    = 1'b0;
        spi_rd_data = 16'h0000;
        forever begin
            @(negedge clk);
            tick++;
            if (tick < HIST) intHist[tick] = INT;
            if (rst) begin
                outstanding = 0;
                txnIdx      = 0;
                expWrtTick  = -1;
                vldTick     = -1;
                expPtch     = '0;
                expAz       = '0;
                spi_done    = 1'b0;
                checkOutput("rst_vld", vld, 0);
                checkOutput("rst_ptch_rt", ptch_rt, 0);
                checkOutput("rst_AZ", AZ, 0);
                checkOutput("rst_spi_wrt", spi_wrt, 0);
            end else begin
                expV = (tick == vldTick);
                if (expV) begin
                    expPtch = pendPtch;
                    expAz   = pendAz;
                    if (intHist[tick-2]) expWrtTick = tick + 1;
                end
                if (vld) vldSeen++;
                checkOutput("vld", vld, expV);
                checkOutput("ptch_rt", ptch_rt, expPtch);
                checkOutput("AZ", AZ, expAz);

                if (spi_wrt) begin
                    cmdLog.push_back(spi_cmd);
                    checkOutput("spi_cmd", spi_cmd, expCmd(txnIdx));
                    checkOutput("wrt_while_busy", outstanding, 0);
                    if (txnIdx == 0) begin
                        checkOutput("first_wrt_time", sinceRst, INIT);
                    end else if (txnIdx >= 4 && ((txnIdx - 4) % 4) == 0) begin
                        checkOutput("read_start_int", intHist[tick-3], 1);
                        if (expWrtTick >= 0) checkOutput("read_start_time", tick, expWrtTick);
                    end else begin
                        checkOutput("wrt_time", tick, expWrtTick);
                    end
                    outstanding = 1;
                    outCmd      = spi_cmd;
                    doneAtTick  = tick + SPI_LAT;
                    txnIdx++;
                    expWrtTick  = -1;
                end else begin
                    if (tick == expWrtTick) checkOutput("missing_wrt", spi_wrt, 1);
                    if (txnIdx == 0 && sinceRst == INIT) checkOutput("missing_first_wrt", spi_wrt, 1);
                    if (outstanding) checkOutput("cmd_stable", spi_cmd, outCmd);
                end

                spi_done    = 1'b0;
                spi_rd_data = 16'h5A5A;
                if (outstanding && tick == doneAtTick) begin
                    spi_done    = 1'b1;
                    spi_rd_data = {upperByte, byteFor(outCmd)};
                    outstanding = 0;
                    case (outCmd)
                        16'hA200: capPL = byteFor(outCmd);
                        16'hA300: capPH = byteFor(outCmd);
                        16'hAC00: capAL = byteFor(outCmd);
                        16'hAD00: capAH = byteFor(outCmd);
                        default: ;
                    endcase
                    if (outCmd == 16'hAD00) begin
                        pendPtch       = {capPH, capPL};
                        pendAz         = {capAH, capAL};
                        vldTick        = tick + 2;
                        lastAhDoneTick = tick;
                    end else if (outCmd != 16'h1460) begin
                        expWrtTick = tick + 1;
                    end
                end else if (injectSpurious && !outstanding) begin
                    spi_done       = 1'b1;
                    spi_rd_data    = 16'hFFFF;
                    injectSpurious = 0;
                end
            end
        end
    end

    task automatic tickWait();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic newRst, input logic newInt);
        @(posedge clk);
        #1;
        rst = newRst;
        INT = newInt;
    endtask

    task automatic waitLog(input int n, input string what);
        int budget = 600;
        while (cmdLog.size() < n && budget > 0) begin
            tickWait();
            budget--;
        end
        if (cmdLog.size() < n) checkOutput({"timeout_", what}, cmdLog.size(), n);
    endtask

    task automatic waitVld(input string what, output int seenTick);
        int budget = 600;
        do begin
            tickWait();
            budget--;
        end while (!vld && budget > 0);
        if (!vld) checkOutput({"timeout_", what}, vld, 1);
        seenTick = tick;
    endtask

    initial begin
        logic [15:0] want [8];
        int t1, t2, t3, baseLen;

        want = '{16'h0D02, 16'h1053, 16'h1150, 16'h1460,
                 16'hA200, 16'hA300, 16'hAC00, 16'hAD00};
        rst = 1'b1;
        INT = 1'b0;
        smpPL = 8'h34; smpPH = 8'h12; smpAL = 8'h78; smpAH = 8'h56;
        upperByte = 8'h00;
        injectSpurious = 0;

        repeat (3) tickWait();
        checkOutput("reset_vld", vld, 0);
        checkOutput("reset_spi_wrt", spi_wrt, 0);
        checkOutput("reset_spi_cmd", spi_cmd, 0);
        checkOutput("reset_ptch_rt", ptch_rt, 0);
        checkOutput("reset_AZ", AZ, 0);
        applyStimulus(0, 0);

        // Init sequence, with INT raised while CFG1 is in flight.
        $display("[TB] init and first sample");
        waitLog(1, "first_cfg");
        checkOutput("init_wait_len", sinceRst, 16);
        waitLog(2, "cfg1");
        applyStimulus(0, 1);
        waitLog(5, "first_read");
        applyStimulus(0, 0);
        waitVld("sample1", t1);
        checkOutput("sample1_ptch_rt", ptch_rt, 16'h1234);
        checkOutput("sample1_AZ", AZ, 16'h5678);
        checkOutput("sample1_latency", t1 - lastAhDoneTick, 2);
        checkOutput("cmd_count", cmdLog.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < cmdLog.size()) checkOutput($sformatf("cmd_seq_%0d", i), cmdLog[i], want[i]);
        end
        repeat (20) tickWait();
        checkOutput("single_vld", vldSeen, 1);

        // Garbage in the upper receive byte must not leak into the sample.
        $display("[TB] upper bytes set");
        upperByte = 8'hFF;
        baseLen = cmdLog.size();
        applyStimulus(0, 1);
        waitLog(baseLen + 1, "upper_read");
        applyStimulus(0, 0);
        waitVld("upper", t1);
        checkOutput("upper_ptch_rt", ptch_rt, 16'h1234);
        checkOutput("upper_AZ", AZ, 16'h5678);

        // INT held high: reads run back to back.
        $display("[TB] back-to-back reads");
        upperByte = 8'h00;
        smpPL = 8'hCD; smpPH = 8'hAB; smpAL = 8'h01; smpAH = 8'hEF;
        applyStimulus(0, 1);
        waitVld("b2b_first", t1);
        checkOutput("b2b_ptch_rt", ptch_rt, 16'hABCD);
        checkOutput("b2b_AZ", AZ, 16'hEF01);
        tickWait();
        checkOutput("b2b_next_wrt", spi_wrt, 1);
        checkOutput("b2b_next_cmd", spi_cmd, 16'hA200);
        checkOutput("b2b_vld_drop", vld, 0);
        waitVld("b2b_second", t2);
        checkOutput("b2b_period", t2 - t1, 46);
        applyStimulus(0, 0);
        waitVld("b2b_third", t3);
        repeat (30) tickWait();
        checkOutput("hold_ptch_rt", ptch_rt, 16'hABCD);
        checkOutput("hold_AZ", AZ, 16'hEF01);
        checkOutput("hold_vld", vld, 0);

        // A done with nothing outstanding must be ignored.
        $display("[TB] spurious done in idle");
        baseLen = cmdLog.size();
        injectSpurious = 1;
        repeat (30) tickWait();
        checkOutput("spurious_no_wrt", cmdLog.size(), baseLen);
        checkOutput("spurious_ptch_rt", ptch_rt, 16'hABCD);

        // Reset in the middle of the AL read restarts everything.
        $display("[TB] reset during RD_AL");
        smpPL = 8'h11; smpPH = 8'h22; smpAL = 8'h33; smpAH = 8'h44;
        applyStimulus(0, 1);
        waitLog(baseLen + 3, "al_read");
        checkOutput("al_read_cmd", cmdLog[cmdLog.size()-1], 16'hAC00);
        applyStimulus(0, 1);
        applyStimulus(1, 0);
        tickWait();
        checkOutput("abort_vld", vld, 0);
        checkOutput("abort_ptch_rt", ptch_rt, 0);
        checkOutput("abort_AZ", AZ, 0);
        applyStimulus(1, 0);
        applyStimulus(0, 0);
        baseLen = cmdLog.size();
        waitLog(baseLen + 1, "restart");
        checkOutput("restart_wait", sinceRst, 16);
        if (cmdLog.size() > baseLen) checkOutput("restart_cmd", cmdLog[baseLen], 16'h0D02);
        waitLog(baseLen + 4, "restart_cfg");
        repeat (15) tickWait();
        checkOutput("restart_no_read", cmdLog.size(), baseLen + 4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got no finish, wanted finish within 30000 cycles");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
